// File: rtl/lcd_cmd_pkg.sv
// Shared definitions for the LCD command sequencer: opcodes, FSM encoding and
// the command ROM word layout.
package lcd_cmd_pkg;

  localparam logic [2:0] OP_WRITE       = 3'd0;
  localparam logic [2:0] OP_SHIFT_UP    = 3'd1;
  localparam logic [2:0] OP_SHIFT_DOWN  = 3'd2;
  localparam logic [2:0] OP_SHIFT_LEFT  = 3'd3;
  localparam logic [2:0] OP_SHIFT_RIGHT = 3'd4;
  localparam logic [2:0] OP_AVERAGE     = 3'd5;
  localparam logic [2:0] OP_MIRROR_X    = 3'd6;
  localparam logic [2:0] OP_MIRROR_Y    = 3'd7;

  // ROM word: {last, opcode[2:0]}
  localparam int OP_LSB   = 0;
  localparam int OP_MSB   = 2;
  localparam int LAST_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT_RDY,
    S_ISSUE,
    S_GAP,
    S_WAIT_DONE,
    S_FINISH
  } seq_state_e;

endpackage

// File: rtl/lcd_cmd_seq_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, flags expiry on the
// LIMIT-th consecutive enabled cycle.
module lcd_cmd_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Command sequencer feeding the LCD controller from a synchronous command ROM.
// Define LCD_CMD_TIMEOUT_EN to add the wait-state watchdog and err flag.
module lcd_cmd_seq
  import lcd_cmd_pkg::*;
#(
  parameter int CMD_AW      = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              CROM_EN,
  output logic [CMD_AW-1:0] CROM_A,
  input  logic [3:0]        CROM_Q,
  input  logic              busy,
  input  logic              done,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [CMD_AW:0]   cmd_count,
  output logic              err
);

  seq_state_e        state_q, state_d;
  logic              crom_en_q, crom_en_d;
  logic [CMD_AW-1:0] crom_a_q, crom_a_d;
  logic [2:0]        cmd_q, cmd_d, op_q, op_d;
  logic              last_q, last_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              seq_busy_q, seq_busy_d;
  logic              seq_done_q, seq_done_d;
  logic [CMD_AW:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef LCD_CMD_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_DONE);

  // The two wait states are never adjacent, so clearing outside them is
  // equivalent to clearing on entry.
  lcd_cmd_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (!in_wait),
    .en_i      (in_wait),
    .expired_o (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    crom_en_d   = 1'b0;
    crom_a_d    = crom_a_q;
    cmd_d       = cmd_q;
    op_d        = op_q;
    last_d      = last_q;
    cmd_valid_d = 1'b0;
    seq_busy_d  = seq_busy_q;
    seq_done_d  = seq_done_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        seq_done_d = 1'b0;
        cnt_d      = '0;
        err_d      = 1'b0;
        crom_a_d   = '0;
        seq_busy_d = 1'b1;
        crom_en_d  = 1'b1;
        state_d    = S_FETCH;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        op_d    = CROM_Q[OP_MSB:OP_LSB];
        last_d  = CROM_Q[LAST_BIT];
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (!busy) begin
          cmd_d       = op_q;
          cmd_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          state_d     = S_ISSUE;
        end else if (timeout) begin
          err_d      = 1'b1;
          seq_busy_d = 1'b0;
          seq_done_d = 1'b1;
          state_d    = S_FINISH;
        end
      end
      S_ISSUE: begin
        if (op_q == OP_WRITE) begin
          state_d = S_WAIT_DONE;
        end else if (last_q || (&crom_a_q)) begin
          seq_busy_d = 1'b0;
          seq_done_d = 1'b1;
          state_d    = S_FINISH;
        end else begin
          crom_a_d = crom_a_q + 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        crom_en_d = 1'b1;
        state_d   = S_FETCH;
      end
      S_WAIT_DONE: begin
        if (done || timeout) begin
          err_d      = !done;
          seq_busy_d = 1'b0;
          seq_done_d = 1'b1;
          state_d    = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      crom_en_q   <= 1'b0;
      crom_a_q    <= '0;
      cmd_q       <= OP_SHIFT_UP;
      op_q        <= OP_SHIFT_UP;
      last_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      crom_en_q   <= crom_en_d;
      crom_a_q    <= crom_a_d;
      cmd_q       <= cmd_d;
      op_q        <= op_d;
      last_q      <= last_d;
      cmd_valid_q <= cmd_valid_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign CROM_EN   = crom_en_q;
  assign CROM_A    = crom_a_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign cmd_count = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Randomized bench for lcd_cmd_seq against a script-level reference model.
module tb_lcd_cmd_seq;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset, start, busy, done;
  logic          CROM_EN, cmd_valid, seq_busy, seq_done, err;
  logic [AW-1:0] CROM_A;
  logic [3:0]    CROM_Q;
  logic [2:0]    cmd;
  logic [AW:0]   cmd_count;

  logic [3:0] rom [DEPTH];
  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int obs_q[$];

  lcd_cmd_seq #(.CMD_AW(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .CROM_EN(CROM_EN), .CROM_A(CROM_A), .CROM_Q(CROM_Q),
    .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
    .seq_busy(seq_busy), .seq_done(seq_done), .cmd_count(cmd_count), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM; output is garbage unless read the previous cycle.
  always @(posedge clk) CROM_Q <= CROM_EN ? rom[CROM_A] : 4'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_crom_en"}, 32'(CROM_EN), 0);
    chk({nm, "_crom_a"}, 32'(CROM_A), 0);
    chk({nm, "_cmd"}, 32'(cmd), 1);
    chk({nm, "_cmd_valid"}, 32'(cmd_valid), 0);
    chk({nm, "_seq_busy"}, 32'(seq_busy), 0);
    chk({nm, "_seq_done"}, 32'(seq_done), 0);
    chk({nm, "_cmd_count"}, 32'(cmd_count), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  // Walk the script: issue every entry up to and including the first Write,
  // the first entry flagged last, or the final ROM address.
  function automatic void model(output bit has_wr);
    exp_q.delete();
    has_wr = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back(int'(rom[a][2:0]));
      if (rom[a][2:0] == 3'd0) begin has_wr = 1'b1; break; end
      if (rom[a][3]) break;
    end
  endfunction

  function automatic void fill_rand();
    for (int a = 0; a < DEPTH; a++) rom[a] = 4'($urandom);
  endfunction

  task automatic run_script(input string nm, input int stall, input int gap_max,
                            input int done_dly, input bit spurious, input bit poke);
    bit has_wr, wr_seen;
    int cyc, first_iss, fall_cyc, done_cyc, fin_cyc, bcnt, dcnt, bad_hold;
    logic [2:0] prev;
    model(has_wr);
    obs_q.delete();
    first_iss = -1; fall_cyc = 0; done_cyc = -1; fin_cyc = -1;
    bad_hold = 0; dcnt = -1; wr_seen = 1'b0;
    busy = (stall > 0); bcnt = stall; done = 1'b0;
    @(negedge clk); start = 1'b1; prev = cmd;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 3000) begin
      if (cmd !== prev && !cmd_valid) bad_hold++;
      prev = cmd;
      if (seq_done) begin fin_cyc = cyc; break; end
      done  = 1'b0;
      start = poke && (cyc == 7);
      if (cmd_valid) begin
        obs_q.push_back(int'(cmd));
        if (first_iss < 0) first_iss = cyc;
        if (cmd == 3'd0) begin dcnt = done_dly; wr_seen = 1'b1; end
        busy = 1'b1;
        bcnt = $urandom_range(gap_max, 0);
      end else if (busy) begin
        if (bcnt > 0) bcnt--;
        else begin
          busy = 1'b0;
          if (first_iss < 0) fall_cyc = cyc;
        end
      end
      if (dcnt > 0) dcnt--;
      else if (dcnt == 0) begin done = 1'b1; done_cyc = cyc; dcnt = -1; end
      else if (spurious && !wr_seen && $urandom_range(7, 0) == 0) done = 1'b1;
      @(negedge clk); cyc++;
    end
    start = 1'b0; done = 1'b0;
    chk({nm, "_finished"}, 32'(fin_cyc >= 0), 1);
    chk({nm, "_n_issued"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({nm, "_cmd"}, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
    chk({nm, "_cmd_count"}, 32'(cmd_count), exp_q.size());
    chk({nm, "_seq_busy"}, 32'(seq_busy), 0);
    chk({nm, "_err"}, 32'(err), 0);
    chk({nm, "_cmd_hold"}, bad_hold, 0);
    chk({nm, "_first_issue"}, first_iss, (stall > 0) ? fall_cyc + 1 : 4);
    if (has_wr) chk({nm, "_done_lat"}, fin_cyc - done_cyc, 1);
    repeat (3) @(negedge clk);
    chk({nm, "_sticky"}, 32'(seq_done), 1);
  endtask

  initial begin
    int iss, nval, fin, cyc;
    reset = 1'b1; start = 1'b0; busy = 1'b0; done = 1'b0;
    fill_rand();
    repeat (3) @(negedge clk);
    chk_rst("rst");
    reset = 1'b0;

    fill_rand();
    rom[0] = 4'h1; rom[1] = 4'h3; rom[2] = 4'h5; rom[3] = 4'h0;
    run_script("basic", 0, 2, 70, 1'b0, 1'b0);
    run_script("stall", 100, 2, 30, 1'b0, 1'b0);

    fill_rand();
    rom[0] = 4'h2; rom[1] = 4'hE;
    run_script("nowrite", 0, 2, 10, 1'b1, 1'b0);

    for (int a = 0; a < DEPTH; a++) rom[a] = 4'h4;
    run_script("full", 0, 1, 10, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++)
        rom[a] = {1'($urandom_range(5, 0) == 0),
                  ($urandom_range(9, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 1))};
      run_script("rnd", (r % 3 == 0) ? int'($urandom_range(30, 5)) : 0,
                 3, int'($urandom_range(40, 1)), 1'b1, 1'b1);
    end

    // Reset while waiting on the third command.
    fill_rand();
    rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h3; rom[3] = 4'hD;
    busy = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    iss = 0; cyc = 0;
    while (iss < 2 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (cmd_valid) begin iss++; if (iss == 2) busy = 1'b1; end
    end
    chk("mid_pre_issues", iss, 2);
    repeat (4) @(negedge clk);
    chk("mid_waiting", 32'(seq_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_rst("mid");
    reset = 1'b0; busy = 1'b0; nval = 0;
    repeat (5) begin @(negedge clk); nval += int'(cmd_valid); end
    chk("mid_quiet", nval, 0);
    run_script("after_rst", 0, 2, 20, 1'b0, 1'b0);

    // Controller stuck busy.
    fill_rand();
    rom[0] = 4'hB;
    busy = 1'b1; nval = 0; fin = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
`ifdef LCD_CMD_TIMEOUT_EN
    cyc = 1;
    while (cyc < 200) begin
      nval += int'(cmd_valid);
      if (seq_done) begin fin = cyc; break; end
      @(negedge clk); cyc++;
    end
    chk("to_finish_cyc", fin, 19);
    chk("to_err", 32'(err), 1);
    chk("to_no_issue", nval, 0);
    chk("to_cmd_count", 32'(cmd_count), 0);
`else
    repeat (1000) begin
      @(negedge clk);
      nval += int'(cmd_valid);
      if (seq_done && fin < 0) fin = 1;
    end
    chk("stuck_seq_busy", 32'(seq_busy), 1);
    chk("stuck_no_done", fin, -1);
    chk("stuck_err", 32'(err), 0);
    chk("stuck_no_issue", nval, 0);
`endif
    busy = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
